// File: rtl/mat_alu_seq_ctrl.sv
// Matrix ALU beat sequencer: latches an issued op, walks rows (outer) and
// K chunks (inner), hands one beat per ready cycle to the datapath, then
// signals completion to the retire unit.
module mat_alu_seq_ctrl #(
    parameter int unsigned MAT_ALU_OP_TYPE_WIDTH = 11,
    parameter int unsigned K_CHUNK_SHIFT         = 4
) (
    input  logic                             forever_cpuclk,
    input  logic                             cpurst_b,
    input  logic                             rtu_yy_xx_flush,
    input  logic                             idu_mat_rf_alu_sel,
    input  logic [6:0]                       idu_mat_rf_pipe8_iid,
    input  logic [MAT_ALU_OP_TYPE_WIDTH-1:0] idu_mat_rf_alu_optype,
    input  logic [7:0]                       x_sizeM,
    input  logic [7:0]                       x_sizeN,
    input  logic [15:0]                      x_sizeK,
    input  logic                             dp_seq_ready,
    output logic                             mat_alu_seq_busy,
    output logic                             seq_dp_vld,
    output logic [7:0]                       seq_dp_row,
    output logic [11:0]                      seq_dp_kidx,
    output logic                             seq_dp_first,
    output logic                             seq_dp_last,
    output logic [MAT_ALU_OP_TYPE_WIDTH-1:0] seq_dp_optype,
    output logic                             mat_alu_cbus_ex1_pipe8_sel,
    output logic [6:0]                       mat_alu_cbus_ex1_pipe8_iid
);

    localparam int unsigned ROW_W   = 8;
    localparam int unsigned KIDX_W  = 12;
    localparam int unsigned IID_W   = 7;
    localparam int unsigned SIZEK_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_CMPLT = 2'd2
    } seq_state_e;

    seq_state_e          state_q;
    logic [IID_W-1:0]    iid_q;
    logic [ROW_W-1:0]    size_m_q;
    logic [KIDX_W-1:0]   kmax_q;
    logic                cmplt_q;

    logic                is_mac_c;
    logic [KIDX_W-1:0]   kmax_issue_c;
    logic                issue_last_c;
    logic                k_wrap_c;
    logic [ROW_W-1:0]    row_nxt_c;
    logic [KIDX_W-1:0]   k_nxt_c;
    logic                last_nxt_c;

    // N size does not influence sequencing; it is only a CFG pass-through.
    logic                unused_size_n;
    assign unused_size_n = ^x_sizeN;

    // Issue-time K chunk count (stored as kcnt-1) and next-beat counter math.
    always_comb begin
        is_mac_c     = |idu_mat_rf_alu_optype[3:1];
        kmax_issue_c = '0;
        if (is_mac_c && (x_sizeK != '0)) begin
            // ceil(K / 2^S) - 1 == floor((K - 1) / 2^S) for K >= 1
            kmax_issue_c = KIDX_W'((x_sizeK - SIZEK_W'(1)) >> K_CHUNK_SHIFT);
        end
        issue_last_c = (x_sizeM == ROW_W'(1)) && (kmax_issue_c == '0);

        k_wrap_c   = (seq_dp_kidx == kmax_q);
        row_nxt_c  = seq_dp_row;
        k_nxt_c    = seq_dp_kidx + KIDX_W'(1);
        if (k_wrap_c) begin
            row_nxt_c = seq_dp_row + ROW_W'(1);
            k_nxt_c   = '0;
        end
        last_nxt_c = (row_nxt_c == (size_m_q - ROW_W'(1))) && (k_nxt_c == kmax_q);
    end

    // Sequencer FSM with registered beat, busy and completion state.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q                    <= ST_IDLE;
            iid_q                      <= '0;
            size_m_q                   <= '0;
            kmax_q                     <= '0;
            cmplt_q                    <= 1'b0;
            mat_alu_seq_busy           <= 1'b0;
            seq_dp_vld                 <= 1'b0;
            seq_dp_row                 <= '0;
            seq_dp_kidx                <= '0;
            seq_dp_first               <= 1'b0;
            seq_dp_last                <= 1'b0;
            seq_dp_optype              <= '0;
            mat_alu_cbus_ex1_pipe8_iid <= '0;
        end else if (rtu_yy_xx_flush) begin
            // Flush wins over everything, including a same-cycle issue.
            state_q                    <= ST_IDLE;
            cmplt_q                    <= 1'b0;
            mat_alu_seq_busy           <= 1'b0;
            seq_dp_vld                 <= 1'b0;
            seq_dp_row                 <= '0;
            seq_dp_kidx                <= '0;
            seq_dp_first               <= 1'b0;
            seq_dp_last                <= 1'b0;
            seq_dp_optype              <= '0;
            mat_alu_cbus_ex1_pipe8_iid <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (idu_mat_rf_alu_sel) begin
                        iid_q            <= idu_mat_rf_pipe8_iid;
                        size_m_q         <= x_sizeM;
                        kmax_q           <= kmax_issue_c;
                        seq_dp_optype    <= idu_mat_rf_alu_optype;
                        seq_dp_row       <= '0;
                        seq_dp_kidx      <= '0;
                        mat_alu_seq_busy <= 1'b1;
                        if (x_sizeM == '0) begin
                            // Empty op: complete without issuing any beat.
                            state_q                    <= ST_CMPLT;
                            cmplt_q                    <= 1'b1;
                            mat_alu_cbus_ex1_pipe8_iid <= idu_mat_rf_pipe8_iid;
                        end else begin
                            state_q      <= ST_RUN;
                            seq_dp_vld   <= 1'b1;
                            seq_dp_first <= 1'b1;
                            seq_dp_last  <= issue_last_c;
                        end
                    end
                end
                ST_RUN: begin
                    if (dp_seq_ready) begin
                        if (seq_dp_last) begin
                            state_q                    <= ST_CMPLT;
                            cmplt_q                    <= 1'b1;
                            mat_alu_cbus_ex1_pipe8_iid <= iid_q;
                            seq_dp_vld                 <= 1'b0;
                            seq_dp_first               <= 1'b0;
                            seq_dp_last                <= 1'b0;
                            seq_dp_row                 <= '0;
                            seq_dp_kidx                <= '0;
                            seq_dp_optype              <= '0;
                        end else begin
                            seq_dp_row   <= row_nxt_c;
                            seq_dp_kidx  <= k_nxt_c;
                            seq_dp_first <= 1'b0;
                            seq_dp_last  <= last_nxt_c;
                        end
                    end
                end
                ST_CMPLT: begin
                    state_q                    <= ST_IDLE;
                    cmplt_q                    <= 1'b0;
                    mat_alu_seq_busy           <= 1'b0;
                    mat_alu_cbus_ex1_pipe8_iid <= '0;
                end
                default: begin
                    state_q          <= ST_IDLE;
                    cmplt_q          <= 1'b0;
                    mat_alu_seq_busy <= 1'b0;
                    seq_dp_vld       <= 1'b0;
                    seq_dp_first     <= 1'b0;
                    seq_dp_last      <= 1'b0;
                end
            endcase
        end
    end

    // A flush arriving in the completion cycle kills that cycle's pulse.
    assign mat_alu_cbus_ex1_pipe8_sel = cmplt_q & ~rtu_yy_xx_flush;

endmodule
